// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready response out.
// Zero-wait response 3 edges after accept; cmd_ready stays low until the response handshake, and ignored commands are not buffered.
module apb_master_bridge #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              cmd_ready_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic [7:0]        err_count_nxt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      err_count   <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    cmd_ready_nxt   = cmd_ready;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    err_count_nxt   = err_count;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_write ? cmd_wdata : '0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          cmd_ready_nxt = 1'b0;
          wait_cnt_nxt  = '0;
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          // This edge is the TIMEOUT_CYCLES-th wait: abort instead of counting further.
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST)) begin
            rsp_rdata_nxt   = '0;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
            psel_nxt        = 1'b0;
            penable_nxt     = 1'b0;
            rsp_valid_nxt   = 1'b1;
            state_nxt       = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
          if (rsp_err && (err_count != 8'hFF)) begin
            err_count_nxt = err_count + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed plan items plus randomized transfers against a transaction-level model.
module tb_apb_master_bridge;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  int err_model = 0;

  apb_master_bridge #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no $finish, required $finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // One complete transfer; the slave answers after 'waits' ACCESS wait cycles (>= TMO: never).
  task automatic do_xfer(input logic w, input logic [3:0] a, input logic [31:0] wd,
                         input int waits, input logic err, input logic [31:0] rd, input int delay);
    logic        exp_to, exp_err, last;
    logic [31:0] exp_rdata, exp_pwdata;
    int          exp_acc, acc;
    exp_to     = (waits >= TMO);
    exp_acc    = exp_to ? TMO : waits + 1;
    exp_err    = exp_to || err;
    exp_rdata  = (w || exp_to) ? 32'd0 : rd;
    exp_pwdata = w ? wd : 32'd0;

    check("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; rsp_ready = 1'b0;
    tick;
    cmd_valid = 1'b0; cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
    check("setup", {psel, penable, pwrite, paddr, pwdata, rsp_valid, cmd_ready},
          {1'b1, 1'b0, w, a, exp_pwdata, 1'b0, 1'b0});
    tick;
    acc = 0;
    for (int c = 0; c < 64; c++) begin
      check("access", {psel, penable, pwrite, paddr, pwdata, rsp_valid, cmd_ready},
            {1'b1, 1'b1, w, a, exp_pwdata, 1'b0, 1'b0});
      acc++;
      last    = (c == waits);
      pready  = last;
      prdata  = last ? rd : $urandom;
      pslverr = last ? err : 1'($urandom);
      tick;
      if (last || acc == TMO) break;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    check("access_cycles", acc, exp_acc);
    check("rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, cmd_ready},
          {1'b1, exp_rdata, exp_err, exp_to, 1'b0, 1'b0, 1'b0});
    for (int d = 0; d < delay; d++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom);
      tick;
      check("rsp_hold", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, cmd_ready},
            {1'b1, exp_rdata, exp_err, exp_to, 1'b0, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    if (exp_err && err_model < 255) err_model++;
    check("handshake", {rsp_valid, cmd_ready, psel, err_count},
          {1'b0, 1'b1, 1'b0, 8'(err_model)});
  endtask

  initial begin
    int r, waits;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #12;
    check("reset_values",
          {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count, cmd_ready},
          {1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1});
    presetn = 1'b1;
    tick;

    do_xfer(1'b1, 4'd1, 32'h0000_0055, 0, 1'b0, 32'hDEAD_BEEF, 0);   // write, zero wait
    do_xfer(1'b0, 4'd6, 32'h1234_5678, 3, 1'b0, 32'h0000_00C0, 0);   // read, 3 waits
    do_xfer(1'b0, 4'd2, 32'd0, 0, 1'b1, 32'hA5A5_0001, 0);           // slave error
    do_xfer(1'b0, 4'd9, 32'd0, TMO + 5, 1'b0, 32'h0BAD_0BAD, 0);     // timeout
    do_xfer(1'b1, 4'd3, 32'hCAFE_F00D, 1, 1'b0, 32'h0, 5);           // backpressure
    do_xfer(1'b0, 4'd4, 32'd0, TMO - 1, 1'b0, 32'h7777_1111, 0);     // last cycle before timeout

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      waits = (r == 9) ? TMO + $urandom_range(0, 3) : r % 5;
      do_xfer(1'($urandom), 4'($urandom), $urandom, waits,
              ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 4));
    end

    for (int i = 0; i < 260; i++) begin
      do_xfer(1'b0, 4'(i), 32'd0, 0, 1'b1, $urandom, 0);
    end
    check("err_saturated", err_count, 8'd255);

    // Kill a transfer mid-ACCESS with an asynchronous reset.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; cmd_wdata = '0;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    #2 presetn = 1'b0;
    #1;
    check("async_reset", {psel, penable, rsp_valid, cmd_ready, err_count},
          {1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
    #2 presetn = 1'b1;
    err_model = 0;
    tick;
    check("post_reset", {cmd_ready, err_count, rsp_valid, psel}, {1'b1, 8'd0, 1'b0, 1'b0});

    for (int i = 0; i < 5; i++) begin
      do_xfer(1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 4),
              1'($urandom), $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
